ps2_device_tx: RTL
==================

// Module: ps2_device_tx
// PURPOSE
// - PS/2 device-side transmitter: serialises bytes into standard 11-bit PS/2 frames and
//   drives ps2_clk/ps2_data as a keyboard would.
// - Used as an on-chip keyboard emulator feeding the team's PS/2 receiver (loopback bring-up)
//   and as the stimulus source in its benches.
// - A 4-entry byte FIFO lets a producer queue multi-byte sequences such as F0 1C.
// PARAMETERS
// HALF_PERIOD  4   clk cycles per ps2_clk half-period (>=2); 2500 gives 10 kHz at 50 MHz
// GAP_CYCLES   8   idle clk cycles (lines high) enforced after each completed frame (>=1)
// FIFO_DEPTH   4   byte FIFO entries, power of 2
// PORTS
// clk           in   1  system clock
// resetn        in   1  synchronous, active-low reset
// tx_valid      in   1  producer presents tx_data
// tx_data       in   8  byte to send
// tx_ready      out  1  FIFO not full; byte accepted on a clk edge with tx_valid & tx_ready
// host_inhibit  in   1  host holds the bus; start of a frame blocked, active frame aborted
// ps2_clk       out  1  PS/2 clock line, idles 1
// ps2_data      out  1  PS/2 data line, idles 1
// busy          out  1  frame in progress or gap running
// frame_done    out  1  1-cycle pulse when a stop bit completes
// BEHAVIOUR
// - Reset (resetn=0 at an edge): FIFO emptied; state IDLE.
//   Outputs after that edge: ps2_clk=1, ps2_data=1, tx_ready=1, busy=0, frame_done=0.
// - Frame: start 0, data[0]..data[7] LSB first, odd parity (~^data), stop 1. Bit index 0..10.
// - All line outputs are registered.
//   Each bit: HALF_PERIOD cycles with ps2_clk=1 and ps2_data=bit, set at phase start;
//   then HALF_PERIOD cycles with ps2_clk=0 and data held.
//   Data is therefore stable HALF_PERIOD cycles before each falling edge.
// - Frame length is 22*HALF_PERIOD cycles. After the stop bit's low phase, ps2_clk=1 and
//   ps2_data=1, and the block enters GAP for GAP_CYCLES cycles.
// - States:
//   - IDLE: ps2_clk=1, ps2_data=1. If FIFO non-empty and !host_inhibit, load the head byte and
//     go to HIGH with bit index 0.
//   - HIGH: count HALF_PERIOD cycles, then go to LOW.
//   - LOW: count HALF_PERIOD cycles. If bit index < 10, increment it and go to HIGH.
//     Otherwise pop the FIFO, pulse frame_done and go to GAP.
//   - GAP: count GAP_CYCLES cycles, then go to IDLE.
// - Latency: a byte written at edge E into an empty, idle block gives ps2_data=0 after edge E+1.
// - The FIFO head is popped only on frame completion.
// - host_inhibit=1 in HIGH or LOW aborts the frame:
//   - Next edge: ps2_clk=1, ps2_data=1, state IDLE, byte not popped, no frame_done.
//   - After inhibit drops, the same byte is resent from its start bit.
// - host_inhibit in GAP or IDLE only holds off the next start.
// - FIFO: tx_ready = !full. A write while full is ignored even if a pop happens in the same
//   cycle. A push and a pop in the same cycle while not full both take effect; count unchanged.
// - busy = (state != IDLE).
// - Reset in the middle of a frame: lines return to 1 at the next edge; frame and queued bytes
//   are discarded.
// - Pointers wrap modulo FIFO_DEPTH. Occupancy counter has FIFO_AW+1 bits.
// TESTING (HALF_PERIOD=4, GAP_CYCLES=8)
// 1. Write 0x1C to an idle block -> bits 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
//    ps2_clk falls 11 times, 8 cycles apart; frame_done pulses at cycle 88.
// 2. Write F0 then 1C back-to-back -> F0 frame has parity 1; exactly 8 idle cycles with both
//    lines high; then the 1C frame. The team's receiver in loopback reports F0, 1C.
// 3. Write 5 bytes in consecutive cycles during a frame -> tx_ready=0 after the 4th queued
//    entry; the 5th is held until the pop, and all bytes are sent in order.
// 4. Assert host_inhibit during data bit 5 of 0x5A for 20 cycles -> lines go high next edge;
//    no frame_done; after release the full 0x5A frame is resent.
// 5. resetn=0 during the 0x1C parity bit with 2 bytes queued -> lines=1 and tx_ready=1 after
//    that edge; no further frames.
// 6. host_inhibit held high while writing 0x33 -> lines stay high; frame starts one edge after
//    release.

Source files
------------

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: byte FIFO feeding an 11-bit frame
// serialiser that drives ps2_clk/ps2_data like a keyboard.
module ps2_device_tx #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       host_inhibit,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int unsigned MAXC =
    (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int unsigned CW = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  state_t      state_q;
  state_t      state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]  bit_q;
  logic [3:0]  bit_d;
  logic [10:0] frame_q;
  logic [10:0] frame_d;
  logic [7:0]  head;
  logic        start;
  logic        clk_d;
  logic        data_d;
  logic        done_d;

  assign full     = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign tx_ready = !full;
  assign push     = tx_valid && !full;
  assign head     = mem[rd_ptr];
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      unique case (1'b1)
        push && !pop: count <= count + (FIFO_AW+1)'(1);
        pop && !push: count <= count - (FIFO_AW+1)'(1);
        default:      count <= count;
      endcase
    end
  end

  // State register; line outputs are registered from next-state values
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '1;
      ps2_clk    <= 1'b1;
      ps2_data   <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      ps2_clk    <= clk_d;
      ps2_data   <= data_d;
      frame_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    start   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty && !host_inhibit) begin
          start   = 1'b1;
          state_d = S_HIGH;
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      S_HIGH: begin
        if (host_inhibit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(HALF_PERIOD - 1)) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LOW: begin
        if (host_inhibit) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(HALF_PERIOD - 1)) begin
          cnt_d = '0;
          if (bit_q < 4'd10) begin
            bit_d   = bit_q + 4'd1;
            state_d = S_HIGH;
          end else begin
            pop     = 1'b1;
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        // Expiry acts as the IDLE decision so the gap is exactly GAP_CYCLES
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (!empty && !host_inhibit) begin
            start   = 1'b1;
            state_d = S_HIGH;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    frame_d = start ? {1'b1, ~^head, head, 1'b0} : frame_q;
    clk_d   = (state_d != S_LOW);
    data_d  = 1'b1;
    if (state_d == S_HIGH || state_d == S_LOW) begin
      data_d = frame_d[bit_d];
    end
    done_d = pop;
  end

endmodule
